// File: rtl/greenled_pio_sequencer_if.sv
// Avalon-MM write-only bus between the LED sequencer (master) and the
// green-LED PIO s1 port (slave).
interface greenled_pio_sequencer_if;
   logic [1:0]  pio_address;
   logic        pio_chipselect;
   logic        pio_write_n;
   logic [31:0] pio_writedata;

   modport master (
      output pio_address,
      output pio_chipselect,
      output pio_write_n,
      output pio_writedata
   );

   modport slave (
      input pio_address,
      input pio_chipselect,
      input pio_write_n,
      input pio_writedata
   );
endinterface

// File: rtl/greenled_pio_sequencer.sv
// Timed LED frame generator (static/blink/rotate/count) that owns the PIO s1
// port and arbitrates its frame writes against one-shot host override writes.
module greenled_pio_sequencer #(
   parameter int LED_W        = 9,
   parameter int PERIOD_W     = 24,
   parameter int RESET_PERIOD = 5000000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          cfg_address,
   input  logic                cfg_chipselect,
   input  logic                cfg_write_n,
   input  logic [31:0]         cfg_writedata,
   output logic [31:0]         cfg_readdata,
   input  logic                host_req,
   input  logic [LED_W-1:0]    host_data,
   output logic                host_ack,
   greenled_pio_sequencer_if.master pio
);

   typedef enum logic [1:0] {IDLE, SEQ_WR, HOST_WR} state_t;

   state_t              state;
   logic                enable;
   logic [1:0]          mode;
   logic [PERIOD_W-1:0] period;
   logic [LED_W-1:0]    pattern;
   logic [LED_W-1:0]    frame;
   logic [PERIOD_W-1:0] count;
   logic                pending;

   logic                cfg_wr, wr_ctrl, wr_period, wr_pattern;
   logic                running, tick, load;
   logic [PERIOD_W-1:0] limit;
   logic [LED_W-1:0]    load_value, tick_frame;
   logic                unused_wdata;

   assign cfg_wr       = cfg_chipselect & ~cfg_write_n;
   assign wr_ctrl      = cfg_wr && (cfg_address == 2'd0);
   assign wr_period    = cfg_wr && (cfg_address == 2'd1);
   assign wr_pattern   = cfg_wr && (cfg_address == 2'd2);
   assign unused_wdata = ^cfg_writedata;

   assign running = enable && (mode != 2'b00);
   // A zero period is treated as one: tick every cycle.
   assign limit   = (period == '0) ? '0 : period - PERIOD_W'(1);
   assign tick    = running && (count >= limit);
   assign load    = (wr_ctrl && cfg_writedata[0] && !enable) || (wr_pattern && enable);
   assign load_value = wr_pattern ? cfg_writedata[LED_W-1:0] : pattern;

   always_comb begin
      tick_frame = frame;
      case (mode)
         2'b01:   tick_frame = (frame == pattern) ? '0 : pattern;
         2'b10:   tick_frame = {frame[LED_W-2:0], frame[LED_W-1]};
         2'b11:   tick_frame = frame + LED_W'(1);
         default: tick_frame = frame;
      endcase
   end

   always_comb begin
      cfg_readdata = '0;
      if (cfg_chipselect) begin
         case (cfg_address)
            2'd0: cfg_readdata = {29'b0, mode, enable};
            2'd1: cfg_readdata = {{(32-PERIOD_W){1'b0}}, period};
            2'd2: cfg_readdata = {{(32-LED_W){1'b0}}, pattern};
            default: cfg_readdata = {14'b0, state != IDLE, pending,
                                     {(16-LED_W){1'b0}}, frame};
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable  <= 1'b0;
         mode    <= 2'b00;
         period  <= PERIOD_W'(RESET_PERIOD);
         pattern <= '0;
         frame   <= '0;
         count   <= '0;
         pending <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            enable <= cfg_writedata[0];
            mode   <= cfg_writedata[2:1];
         end
         if (wr_period)  period  <= cfg_writedata[PERIOD_W-1:0];
         if (wr_pattern) pattern <= cfg_writedata[LED_W-1:0];

         if (wr_period || load || tick || !running) count <= '0;
         else                                       count <= count + PERIOD_W'(1);

         if (load)      frame <= load_value;
         else if (tick) frame <= tick_frame;

         // Disable beats a new tick/load, which beats consumption by a write.
         if (wr_ctrl && !cfg_writedata[0]) pending <= 1'b0;
         else if (load || tick)            pending <= 1'b1;
         else if (!host_req)               pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state              <= IDLE;
         pio.pio_address    <= '0;
         pio.pio_chipselect <= 1'b0;
         pio.pio_write_n    <= 1'b1;
         pio.pio_writedata  <= '0;
         host_ack           <= 1'b0;
      end else begin
         pio.pio_address <= '0;
         if (host_req) begin
            state              <= HOST_WR;
            pio.pio_chipselect <= 1'b1;
            pio.pio_write_n    <= 1'b0;
            pio.pio_writedata  <= {{(32-LED_W){1'b0}}, host_data};
            host_ack           <= 1'b1;
         end else if (pending) begin
            state              <= SEQ_WR;
            pio.pio_chipselect <= 1'b1;
            pio.pio_write_n    <= 1'b0;
            pio.pio_writedata  <= {{(32-LED_W){1'b0}}, frame};
            host_ack           <= 1'b0;
         end else begin
            state              <= IDLE;
            pio.pio_chipselect <= 1'b0;
            pio.pio_write_n    <= 1'b1;
            host_ack           <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_greenled_pio_sequencer.sv
// Directed plus randomized bench for greenled_pio_sequencer against a
// cycle-level behavioural model of the configuration and arbitration rules.
module tb_greenled_pio_sequencer;

   logic        clk;
   logic        reset_n;
   logic [1:0]  cfg_address;
   logic        cfg_chipselect;
   logic        cfg_write_n;
   logic [31:0] cfg_writedata;
   logic [31:0] cfg_readdata;
   logic        host_req;
   logic [8:0]  host_data;
   logic        host_ack;

   greenled_pio_sequencer_if pio_bus ();

   greenled_pio_sequencer #(
      .LED_W        (9),
      .PERIOD_W     (24),
      .RESET_PERIOD (5000000)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cfg_address    (cfg_address),
      .cfg_chipselect (cfg_chipselect),
      .cfg_write_n    (cfg_write_n),
      .cfg_writedata  (cfg_writedata),
      .cfg_readdata   (cfg_readdata),
      .host_req       (host_req),
      .host_data      (host_data),
      .host_ack       (host_ack),
      .pio            (pio_bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Behavioural model state
   bit          m_en;
   logic [1:0]  m_mode;
   logic [31:0] m_period, m_pat, m_frame, m_cnt;
   bit          m_pend, exp_cs, exp_ack;
   logic [31:0] exp_data;

   logic [31:0] log_data[$];
   int          log_cyc[$];
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 0; m_mode = 2'b00; m_period = 32'd5000000; m_pat = 0;
      m_frame = 0; m_cnt = 0; m_pend = 0;
      exp_cs = 0; exp_ack = 0; exp_data = 0;
   endtask

   task automatic model_edge();
      bit wr, running, tick, np;
      logic [31:0] lim, nf, nc;
      if (!reset_n) begin
         model_reset();
         return;
      end
      wr      = cfg_chipselect && !cfg_write_n;
      running = m_en && (m_mode != 2'b00);
      lim     = (m_period == 0) ? 32'd1 : m_period;
      tick    = running && (m_cnt >= lim - 1);
      if (host_req) begin
         exp_cs = 1; exp_ack = 1; exp_data = {23'b0, host_data};
      end else if (m_pend) begin
         exp_cs = 1; exp_ack = 0; exp_data = m_frame;
      end else begin
         exp_cs = 0; exp_ack = 0;
      end
      nf = m_frame;
      np = m_pend && host_req;
      nc = running ? m_cnt + 1 : 0;
      if (tick) begin
         nc = 0;
         np = 1;
         case (m_mode)
            2'b01:   nf = (m_frame == m_pat) ? 32'd0 : m_pat;
            2'b10:   nf = ((m_frame << 1) | (m_frame >> 8)) & 32'h1FF;
            default: nf = (m_frame + 1) & 32'h1FF;
         endcase
      end
      if (wr) begin
         case (cfg_address)
            2'd0: begin
               if (cfg_writedata[0] && !m_en) begin nf = m_pat; nc = 0; np = 1; end
               if (!cfg_writedata[0]) np = 0;
               m_en   = cfg_writedata[0];
               m_mode = cfg_writedata[2:1];
            end
            2'd1: begin m_period = cfg_writedata & 32'hFF_FFFF; nc = 0; end
            2'd2: begin
               m_pat = cfg_writedata & 32'h1FF;
               if (m_en) begin nf = m_pat; nc = 0; np = 1; end
            end
            default: ;
         endcase
      end
      m_frame = nf; m_cnt = nc; m_pend = np;
   endtask

   function automatic logic [31:0] rd_model();
      if (!cfg_chipselect) return 32'd0;
      case (cfg_address)
         2'd0:    return {29'b0, m_mode, m_en};
         2'd1:    return m_period;
         2'd2:    return m_pat;
         default: return m_frame | (32'(m_pend) << 16) | (32'(exp_cs) << 17);
      endcase
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      chk("pio_chipselect", {31'b0, pio_bus.pio_chipselect}, {31'b0, exp_cs});
      chk("pio_write_n", {31'b0, pio_bus.pio_write_n}, {31'b0, !exp_cs});
      if (exp_cs) begin
         chk("pio_writedata", pio_bus.pio_writedata, exp_data);
         chk("pio_address", {30'b0, pio_bus.pio_address}, 32'd0);
      end
      chk("host_ack", {31'b0, host_ack}, {31'b0, exp_ack});
      chk("cfg_readdata", cfg_readdata, rd_model());
      if (pio_bus.pio_chipselect && !pio_bus.pio_write_n) begin
         log_data.push_back(pio_bus.pio_writedata);
         log_cyc.push_back(cyc);
      end
   endtask

   task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
      cfg_address = a; cfg_writedata = d; cfg_chipselect = 1; cfg_write_n = 0;
      step();
      cfg_chipselect = 0; cfg_write_n = 1;
   endtask

   task automatic cfg_rd(input logic [1:0] a, input logic [31:0] d, input string tag);
      cfg_address = a; cfg_chipselect = 1; cfg_write_n = 1;
      #1;
      chk(tag, cfg_readdata, d);
      step();
      cfg_chipselect = 0;
   endtask

   task automatic clear_log();
      log_data.delete();
      log_cyc.delete();
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_count"}, 32'(log_data.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_data.size(); i++)
         chk({tag, "_data"}, log_data[i], exp_q[i]);
   endtask

   initial begin
      logic [31:0] f0;
      int r;
      reset_n = 0; cfg_address = 0; cfg_chipselect = 0; cfg_write_n = 1;
      cfg_writedata = 0; host_req = 0; host_data = 0;
      model_reset();
      repeat (3) step();
      chk("reset_cs", {31'b0, pio_bus.pio_chipselect}, 32'd0);
      chk("reset_wr_n", {31'b0, pio_bus.pio_write_n}, 32'd1);
      chk("reset_wdata", pio_bus.pio_writedata, 32'd0);
      reset_n = 1;

      cfg_rd(2'd3, 32'd0, "status_after_reset");
      cfg_rd(2'd1, 32'd5000000, "period_after_reset");
      clear_log();
      repeat (100) step();
      chk("no_write_after_reset", 32'(log_data.size()), 32'd0);

      // Blink at period 4
      cfg_wr(2'd1, 32'd4);
      cfg_wr(2'd2, 32'h0A5);
      clear_log();
      cfg_wr(2'd0, 32'h3);
      repeat (13) step();
      exp_q = '{32'h0A5, 32'h000, 32'h0A5, 32'h000};
      check_log("blink");
      for (int i = 1; i < log_cyc.size(); i++)
         chk("blink_gap", 32'(log_cyc[i] - log_cyc[i-1]), 32'd4);

      // Rotate at period 1
      cfg_wr(2'd0, 32'h0);
      repeat (3) step();
      cfg_wr(2'd1, 32'd1);
      cfg_wr(2'd2, 32'h100);
      clear_log();
      cfg_wr(2'd0, 32'h5);
      repeat (3) step();
      exp_q = '{32'h100, 32'h001, 32'h002};
      check_log("rotate");

      // Count wraps
      cfg_wr(2'd0, 32'h0);
      repeat (3) step();
      cfg_wr(2'd2, 32'h1FF);
      clear_log();
      cfg_wr(2'd0, 32'h7);
      repeat (2) step();
      exp_q = '{32'h1FF, 32'h000};
      check_log("count_wrap");

      // Host request coincident with a tick
      cfg_wr(2'd0, 32'h0);
      repeat (3) step();
      cfg_wr(2'd1, 32'd4);
      cfg_wr(2'd2, 32'h010);
      clear_log();
      cfg_wr(2'd0, 32'h7);
      repeat (3) step();
      host_data = 9'h155; host_req = 1;
      step();
      chk("collide_ack", {31'b0, host_ack}, 32'd1);
      host_req = 0;
      step();
      exp_q = '{32'h010, 32'h155, 32'h011};
      check_log("collide");

      // Coalescing under held host_req
      cfg_wr(2'd1, 32'd2);
      clear_log();
      host_req = 1;
      repeat (6) step();
      host_req = 0;
      step();
      exp_q = '{32'h155, 32'h155, 32'h155, 32'h155, 32'h155, 32'h155, 32'h014};
      check_log("coalesce");

      // Disable while pending and host held: sequencer write is dropped
      host_req = 1;
      cfg_wr(2'd2, 32'h0F0);
      cfg_wr(2'd0, 32'h0);
      host_req = 0;
      clear_log();
      repeat (5) step();
      chk("disable_no_write", 32'(log_data.size()), 32'd0);

      // Asynchronous reset mid-strobe
      host_data = 9'h0AA; host_req = 1;
      step();
      reset_n = 0;
      #1;
      chk("async_cs", {31'b0, pio_bus.pio_chipselect}, 32'd0);
      chk("async_wr_n", {31'b0, pio_bus.pio_write_n}, 32'd1);
      chk("async_ack", {31'b0, host_ack}, 32'd0);
      host_req = 0;
      repeat (2) step();
      reset_n = 1;
      repeat (2) step();

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         cfg_chipselect = 0; cfg_write_n = 1;
         r = int'($urandom % 100);
         cfg_address = 2'($urandom % 4);
         if (r < 4) begin
            cfg_chipselect = 1; cfg_write_n = 0;
            case (cfg_address)
               2'd0:    cfg_writedata = $urandom % 8;
               2'd1:    cfg_writedata = ($urandom & 32'hFF00_0000) | ($urandom % 6);
               default: cfg_writedata = $urandom;
            endcase
         end else if (r < 12) begin
            cfg_chipselect = 1;
         end
         if (host_req && host_ack && ($urandom % 8 != 0)) host_req = 0;
         else if (!host_req && ($urandom % 16 == 0)) begin
            host_req = 1;
            host_data = 9'($urandom);
         end
         step();
      end
      f0 = 32'(vectors);
      chk("random_ran", 32'(vectors) - f0 + 32'(miscompares), 32'(miscompares));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
